main_mem_arbiter: RTL

- Shares the single `main_memory` port between two requesters: requester 0 (instruction fetch) and requester 1 (data load/store, or a debug/loader port).
- Sits between the requesters and `main_memory`, replacing the direct mux in `main_memory_control`.
- Arbitrates per cycle with round-robin fairness.
- Tracks outstanding reads so each read return is steered to the requester that issued it.

---
 rtl/main_mem_arbiter_pkg.sv | 40 ++++
 rtl/main_mem_arbiter_if.sv | 60 ++++++
 rtl/arb_rd_tracker.sv | 35 +++
 rtl/main_mem_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// Shared types, constants and helpers for the main_memory arbiter.
package main_mem_arbiter_pkg;

  // Requester identifiers as carried in the read tracker and last-grant register.
  localparam logic ARB_OWNER_R0 = 1'b0;
  localparam logic ARB_OWNER_R1 = 1'b1;

  // Deepest supported read return pipeline.
  localparam int ARB_MAX_RD_LATENCY = 3;

  // Exclusive-ownership state used when locked accesses are enabled.
  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED_R0 = 2'd1,
    LOCKED_R1 = 2'd2
  } lock_state_t;

  // Round-robin pick: bit 0 grants r0, bit 1 grants r1; on contention the
  // requester that did not win last time gets the slot.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1,
                                         input logic last_gnt);
    logic [1:0] g;
    g = 2'b00;
    if (req0 && req1) begin
      if (last_gnt == ARB_OWNER_R1) begin
        g = 2'b01;
      end else begin
        g = 2'b10;
      end
    end else if (req0) begin
      g = 2'b01;
    end else if (req1) begin
      g = 2'b10;
    end else begin
      g = 2'b00;
    end
    return g;
  endfunction

endpackage

// File: rtl/main_mem_arbiter_if.sv
// Requester and main_memory bundle seen by the arbiter.
// Lock inputs exist only when MEM_ARB_LOCK_EN is defined.
interface main_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

`ifdef MEM_ARB_LOCK_EN
  logic              r0_lock;
  logic              r1_lock;
`endif
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  r0_lock, r1_lock,
`endif
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_wen,
    input  mem_rdata
  );

  // Requester / memory side.
  modport master (
`ifdef MEM_ARB_LOCK_EN
    output r0_lock, r1_lock,
`endif
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wen,
    output mem_rdata
  );

endinterface

// File: rtl/arb_rd_tracker.sv
// Read-return tracker: a DEPTH-deep {valid, owner} shift register so each
// memory read return is steered to the requester that issued it.
module arb_rd_tracker #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_valid_i,
  input  logic push_owner_i,
  output logic tail_valid_o,
  output logic tail_owner_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] owner_q;

  // Shift one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= {DEPTH{1'b0}};
      owner_q <= {DEPTH{1'b0}};
    end else begin
      valid_q[0] <= push_valid_i;
      owner_q[0] <= push_valid_i & push_owner_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign tail_valid_o = valid_q[DEPTH-1];
  assign tail_owner_o = owner_q[DEPTH-1];

endmodule

// File: rtl/main_mem_arbiter.sv
// Two-requester round-robin arbiter for the single main_memory port.
// Optional feature macro: MEM_ARB_LOCK_EN adds r0_lock/r1_lock for atomic
// read-modify-write ownership.
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  main_mem_arbiter_if.slave bus
);

  logic [1:0]        gnt_s;
  logic              any_gnt_s;
  logic              sel_r1_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [ADDR_W-1:0] mem_raddr_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              mem_wen_s;
  logic              rd_push_s;
  logic              tail_valid_s;
  logic              tail_owner_s;
  logic              r0_rvalid_s;
  logic              r1_rvalid_s;
  logic              last_gnt_d;
  logic              last_gnt_q;
  logic              blk0_s;
  logic              blk1_s;

`ifdef MEM_ARB_LOCK_EN
  lock_state_t lock_q;

  // The non-owner is shut out while a locked sequence is in progress.
  assign blk0_s = (lock_q == LOCKED_R1);
  assign blk1_s = (lock_q == LOCKED_R0);

  // Lock FSM: a locked grant takes ownership, an unlocked grant by the owner releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= UNLOCKED;
    end else begin
      case (lock_q)
        UNLOCKED: begin
          if (gnt_s[0] && bus.r0_lock) begin
            lock_q <= LOCKED_R0;
          end else if (gnt_s[1] && bus.r1_lock) begin
            lock_q <= LOCKED_R1;
          end else begin
            lock_q <= UNLOCKED;
          end
        end
        LOCKED_R0: begin
          if (gnt_s[0] && !bus.r0_lock) begin
            lock_q <= UNLOCKED;
          end else begin
            lock_q <= LOCKED_R0;
          end
        end
        LOCKED_R1: begin
          if (gnt_s[1] && !bus.r1_lock) begin
            lock_q <= UNLOCKED;
          end else begin
            lock_q <= LOCKED_R1;
          end
        end
        default: lock_q <= UNLOCKED;
      endcase
    end
  end
`else
  assign blk0_s = 1'b0;
  assign blk1_s = 1'b0;
`endif

  // Grant selection and the request mux for the winning requester.
  always_comb begin
    gnt_s       = rr_pick(bus.r0_req & ~blk0_s, bus.r1_req & ~blk1_s, last_gnt_q);
    any_gnt_s   = |gnt_s;
    sel_r1_s    = gnt_s[1];
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (gnt_s[1]) begin
      sel_we_s    = bus.r1_we;
      sel_addr_s  = bus.r1_addr;
      sel_wdata_s = bus.r1_wdata;
    end else if (gnt_s[0]) begin
      sel_we_s    = bus.r0_we;
      sel_addr_s  = bus.r0_addr;
      sel_wdata_s = bus.r0_wdata;
    end else begin
      sel_we_s    = 1'b0;
    end
  end

  // Drive main_memory: only the granted access is visible, everything else is zero.
  always_comb begin
    mem_raddr_s = {ADDR_W{1'b0}};
    mem_waddr_s = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    mem_wen_s   = 1'b0;
    if (any_gnt_s && sel_we_s) begin
      mem_waddr_s = sel_addr_s;
      mem_wdata_s = sel_wdata_s;
      mem_wen_s   = 1'b1;
    end else if (any_gnt_s) begin
      mem_raddr_s = sel_addr_s;
    end else begin
      mem_wen_s   = 1'b0;
    end
  end

  // Next value of the round-robin pointer: it moves only when someone is granted.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (any_gnt_s) begin
      last_gnt_d = sel_r1_s;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // Round-robin pointer; reset favours r0 at the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= ARB_OWNER_R1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign rd_push_s = any_gnt_s & ~sel_we_s;

  generate
    if (RD_LATENCY == 0) begin : g_no_trk
      // Zero latency: memory returns data in the grant cycle itself.
      assign tail_valid_s = rd_push_s;
      assign tail_owner_s = sel_r1_s;
    end else begin : g_trk
      arb_rd_tracker #(
        .DEPTH (RD_LATENCY)
      ) u_rd_tracker (
        .clk_i        (clk),
        .rst_ni       (rst),
        .push_valid_i (rd_push_s),
        .push_owner_i (sel_r1_s),
        .tail_valid_o (tail_valid_s),
        .tail_owner_o (tail_owner_s)
      );
    end
  endgenerate

  assign r0_rvalid_s = tail_valid_s & (tail_owner_s == ARB_OWNER_R0);
  assign r1_rvalid_s = tail_valid_s & (tail_owner_s == ARB_OWNER_R1);

  assign bus.r0_gnt    = gnt_s[0];
  assign bus.r1_gnt    = gnt_s[1];
  assign bus.r0_rvalid = r0_rvalid_s;
  assign bus.r1_rvalid = r1_rvalid_s;
  assign bus.r0_rdata  = r0_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.r1_rdata  = r1_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.mem_raddr = mem_raddr_s;
  assign bus.mem_waddr = mem_waddr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.mem_wen   = mem_wen_s;

endmodule
